// File: rtl/physical_tx_gearbox.sv
// Multi-lane transmit gearbox: packs IN_WIDTH-bit line symbols into a continuous
// OUT_WIDTH-bit-per-clock stream, inserting idle or training symbols when needed.
module physical_tx_gearbox #(
   parameter int                  LANES      = 1,
   parameter int                  IN_WIDTH   = 10,
   parameter int                  OUT_WIDTH  = 4,
   parameter bit                  LSB_FIRST  = 1'b1,
   parameter logic [IN_WIDTH-1:0] IDLE_WORD  = 10'h283,
   parameter logic [IN_WIDTH-1:0] TRAIN_WORD = 10'h155
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [LANES*IN_WIDTH-1:0]    i_data,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic                         i_train,
   output logic [LANES*OUT_WIDTH-1:0]   o_data,
   output logic                         o_underrun,
   output logic                         o_word_start
);

   localparam int BUF_W = IN_WIDTH + OUT_WIDTH - 1;
   localparam int FW    = $clog2(BUF_W + 1);
   localparam logic [FW-1:0] OUT_F  = FW'(OUT_WIDTH);
   localparam logic [FW-1:0] STEP_F = FW'(IN_WIDTH - OUT_WIDTH);

   if (IN_WIDTH < OUT_WIDTH) begin : g_width_check
      $error("physical_tx_gearbox: IN_WIDTH must be >= OUT_WIDTH");
   end

   logic [BUF_W-1:0]           buf_q [LANES];
   logic [BUF_W-1:0]           buf_d [LANES];
   logic [FW-1:0]              fill_q, fill_d;
   logic [LANES*OUT_WIDTH-1:0] data_q, data_d;
   logic                       underrun_q, word_start_q;
   logic                       load;
   logic [BUF_W-1:0]           mask;

   function automatic logic [IN_WIDTH-1:0] bit_rev(input logic [IN_WIDTH-1:0] s);
      logic [IN_WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < IN_WIDTH; i++) r[i] = s[IN_WIDTH-1-i];
      return r;
   endfunction

   // Lanes share fill and load; only the symbol source differs per lane.
   always_comb begin
      logic [IN_WIDTH-1:0] sym;
      logic [BUF_W-1:0]    comb;
      load   = (fill_q < OUT_F);
      mask   = (BUF_W'(1) << fill_q) - BUF_W'(1);
      fill_d = load ? (fill_q + STEP_F) : (fill_q - OUT_F);
      data_d = '0;
      sym    = '0;
      comb   = '0;
      for (int l = 0; l < LANES; l++) begin
         if (i_train)      sym = TRAIN_WORD;
         else if (i_valid) sym = i_data[l*IN_WIDTH +: IN_WIDTH];
         else              sym = IDLE_WORD;
         if (!LSB_FIRST) sym = bit_rev(sym);
         comb = load ? ((BUF_W'(sym) << fill_q) | (buf_q[l] & mask)) : buf_q[l];
         data_d[l*OUT_WIDTH +: OUT_WIDTH] = comb[OUT_WIDTH-1:0];
         buf_d[l] = comb >> OUT_WIDTH;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int l = 0; l < LANES; l++) buf_q[l] <= '0;
         fill_q       <= '0;
         data_q       <= '0;
         underrun_q   <= 1'b0;
         word_start_q <= 1'b0;
      end else begin
         for (int l = 0; l < LANES; l++) buf_q[l] <= buf_d[l];
         fill_q       <= fill_d;
         data_q       <= data_d;
         underrun_q   <= load && !i_train && !i_valid;
         word_start_q <= load;
      end
   end

   assign o_ready      = load && !i_train && !i_rst;
   assign o_data       = data_q;
   assign o_underrun   = underrun_q;
   assign o_word_start = word_start_q;

endmodule

// File: tb/tb_physical_tx_gearbox.sv
// Directed bench for physical_tx_gearbox: LSB-first single lane, MSB-first single
// lane and a four-lane instance share control inputs and so run in lockstep.
module tb_physical_tx_gearbox;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, valid, train;
   logic [9:0]  da, db;
   logic [39:0] dc;
   logic        rdy_a, ur_a, ws_a;
   logic        rdy_b, ur_b, ws_b;
   logic        rdy_c, ur_c, ws_c;
   logic [3:0]  od_a, od_b;
   logic [15:0] od_c;

   int n_checks = 0;
   int n_fail   = 0;

   physical_tx_gearbox #(.LANES(1), .LSB_FIRST(1'b1)) u_a (
      .i_clk(clk), .i_rst(rst), .i_data(da), .i_valid(valid), .o_ready(rdy_a),
      .i_train(train), .o_data(od_a), .o_underrun(ur_a), .o_word_start(ws_a));

   physical_tx_gearbox #(.LANES(1), .LSB_FIRST(1'b0)) u_b (
      .i_clk(clk), .i_rst(rst), .i_data(db), .i_valid(valid), .o_ready(rdy_b),
      .i_train(train), .o_data(od_b), .o_underrun(ur_b), .o_word_start(ws_b));

   physical_tx_gearbox #(.LANES(4), .LSB_FIRST(1'b1)) u_c (
      .i_clk(clk), .i_rst(rst), .i_data(dc), .i_valid(valid), .o_ready(rdy_c),
      .i_train(train), .o_data(od_c), .o_underrun(ur_c), .o_word_start(ws_c));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check o_ready before the edge, then the registered outputs after it.
   task automatic beat(input string tag, input logic rdy, input logic [3:0] d,
                       input logic ws, input logic ur);
      #1;
      check_val({tag, ".ready_a"}, rdy_a, rdy);
      check_val({tag, ".ready_b"}, rdy_b, rdy);
      check_val({tag, ".ready_c"}, rdy_c, rdy);
      tick();
      check_val({tag, ".data"}, od_a, d);
      check_val({tag, ".word_start"}, ws_a, ws);
      check_val({tag, ".underrun"}, ur_a, ur);
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; train = 1'b0;
      da = '0; db = '0; dc = '0;
      tick();
      tick();
      check_val("rst.ready", rdy_a, 1'b0);
      check_val("rst.data", od_a, 4'h0);
      check_val("rst.data_c", od_c, 16'h0);
      check_val("rst.ws", ws_a, 1'b0);
      check_val("rst.ur", ur_a, 1'b0);

      // continuous data, plus MSB-first and four-lane instances
      rst = 1'b0; valid = 1'b1;
      da = 10'h3FF; db = 10'h200; dc = {10'h155, 10'h283, 10'h000, 10'h3FF};
      beat("t1c0", 1'b1, 4'hF, 1'b1, 1'b0);
      check_val("t1c0.msb_first", od_b, 4'h1);
      check_val("t1c0.lanes", od_c, 16'h530F);
      da = 10'h000; db = 10'h001; dc = {10'h2AA, 10'h001, 10'h3FF, 10'h000};
      beat("t1c1", 1'b0, 4'hF, 1'b0, 1'b0);
      check_val("t1c1.lanes", od_c, 16'h580F);
      beat("t1c2", 1'b1, 4'h3, 1'b1, 1'b0);
      check_val("t1c2.lanes", od_c, 16'h96C3);
      beat("t1c3", 1'b0, 4'h0, 1'b0, 1'b0);
      check_val("t1c3.lanes", od_c, 16'hA0F0);
      beat("t1c4", 1'b0, 4'h0, 1'b0, 1'b0);
      check_val("t1c4.msb_first", od_b, 4'h8);
      check_val("t1c4.lanes", od_c, 16'hA0F0);

      // underrun: idle symbols
      rst = 1'b1;
      beat("rst2", 1'b0, 4'h0, 1'b0, 1'b0);
      rst = 1'b0; valid = 1'b0;
      beat("t2c0", 1'b1, 4'h3, 1'b1, 1'b1);
      check_val("t2c0.idle_msb", od_b, 4'h5);
      check_val("t2c0.idle_lanes", od_c, 16'h3333);
      beat("t2c1", 1'b0, 4'h8, 1'b0, 1'b0);
      beat("t2c2", 1'b1, 4'hE, 1'b1, 1'b1);
      beat("t2c3", 1'b0, 4'h0, 1'b0, 1'b0);
      beat("t2c4", 1'b0, 4'hA, 1'b0, 1'b0);
      beat("t2c5", 1'b1, 4'h3, 1'b1, 1'b1);

      // training raised at fill=6, dropped at fill=8
      rst = 1'b1;
      beat("rst3", 1'b0, 4'h0, 1'b0, 1'b0);
      rst = 1'b0; valid = 1'b1; da = 10'h3C5;
      beat("t3c0", 1'b1, 4'h5, 1'b1, 1'b0);
      train = 1'b1;
      beat("t3c1", 1'b0, 4'hC, 1'b0, 1'b0);
      beat("t3c2", 1'b0, 4'h7, 1'b1, 1'b0);
      train = 1'b0;
      beat("t3c3", 1'b0, 4'h5, 1'b0, 1'b0);
      beat("t3c4", 1'b0, 4'h5, 1'b0, 1'b0);
      da = 10'h001;
      beat("t3c5", 1'b1, 4'h1, 1'b1, 1'b0);

      // reset at fill=8 discards buffered ones
      da = 10'h3FF;
      beat("t6a", 1'b0, 4'h0, 1'b0, 1'b0);
      beat("t6b", 1'b1, 4'hC, 1'b1, 1'b0);
      rst = 1'b1;
      beat("t6rst", 1'b0, 4'h0, 1'b0, 1'b0);
      rst = 1'b0; da = 10'h000;
      beat("t6c0", 1'b1, 4'h0, 1'b1, 1'b0);
      beat("t6c1", 1'b0, 4'h0, 1'b0, 1'b0);
      beat("t6c2", 1'b1, 4'h0, 1'b1, 1'b0);
      beat("t6c3", 1'b0, 4'h0, 1'b0, 1'b0);
      beat("t6c4", 1'b0, 4'h0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
